// File: rtl/gate_sweep_pkg.sv
// Shared op codes and FSM state encodings for the gate sweep controller.
package gate_sweep_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Control/result bundle between a sweep requester (master) and gate_sweep_ctrl (slave).
// Optional result_map signal exists only when GATE_SWEEP_MAP_EN is defined.
interface gate_sweep_ctrl_if #(
  parameter int N = 3
);
  // start is a level request sampled only in IDLE; done is a one-cycle pulse.
  logic           start;
  logic           abort;
  logic [1:0]     op;
  logic           dut_s;
  logic [N-1:0]   vec_out;
  logic           busy;
  logic           done;
  logic           pass;
  logic [N:0]     err_count;
  logic [N-1:0]   first_err_vec;
  logic           first_err_vld;
  logic [1:0]     state;
`ifdef GATE_SWEEP_MAP_EN
  logic [2**N-1:0] result_map;
`endif

  modport master (
    output start, abort, op, dut_s,
    input  vec_out, busy, done, pass, err_count, first_err_vec, first_err_vld, state
`ifdef GATE_SWEEP_MAP_EN
    , input result_map
`endif
  );

  modport slave (
    input  start, abort, op, dut_s,
    output vec_out, busy, done, pass, err_count, first_err_vec, first_err_vld, state
`ifdef GATE_SWEEP_MAP_EN
    , output result_map
`endif
  );

endinterface

// File: rtl/gate_ref_model.sv
// Combinational reference for the gate family: reduction OR/AND/XOR/NOR of vec.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] vec,
  input  logic [1:0]   op,
  output logic         exp_s
);

  always_comb begin
    exp_s = 1'b0;
    case (op)
      OP_OR:   exp_s = |vec;
      OP_AND:  exp_s = &vec;
      OP_XOR:  exp_s = ^vec;
      OP_NOR:  exp_s = ~|vec;
      default: exp_s = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweep of an external N-input gate with settle delay and error capture.
// Define GATE_SWEEP_MAP_EN to add the per-vector mismatch bitmap (result_map).
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int N      = 3,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst,
  gate_sweep_ctrl_if.slave   bus
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  logic [1:0]    state_q;
  logic [1:0]    op_q;
  logic [N-1:0]  vec_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [N:0]    err_q;
  logic [N-1:0]  fev_q;
  logic          fevld_q;
`ifdef GATE_SWEEP_MAP_EN
  logic [2**N-1:0] map_q;
`endif

  logic          exp_s;
  logic          mismatch;
  logic [N:0]    err_next;

  gate_ref_model #(.N(N)) u_ref (
    .vec   (vec_q),
    .op    (op_q),
    .exp_s (exp_s)
  );

  assign mismatch = (bus.dut_s != exp_s);
  assign err_next = err_q + (N+1)'(mismatch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_OR;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= '0;
      fevld_q <= 1'b0;
`ifdef GATE_SWEEP_MAP_EN
      map_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // abort in the same cycle suppresses the start request
          if (bus.start && !bus.abort) begin
            op_q    <= bus.op;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fevld_q <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef GATE_SWEEP_MAP_EN
            map_q   <= '0;
`endif
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
            pass_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(SETTLE - 1)) state_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            vec_q   <= '0;
            pass_q  <= 1'b0;
          end else begin
            if (mismatch) begin
              err_q <= err_next;
              if (!fevld_q) begin
                fev_q   <= vec_q;
                fevld_q <= 1'b1;
              end
`ifdef GATE_SWEEP_MAP_EN
              map_q[vec_q] <= 1'b1;
`endif
            end
            // terminal vector detected explicitly so the counter never wraps
            if (vec_q == {N{1'b1}}) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              pass_q  <= (err_next == '0);
            end else begin
              vec_q   <= vec_q + N'(1);
              cnt_q   <= '0;
              state_q <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          vec_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.vec_out       = vec_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_vec = fev_q;
  assign bus.first_err_vld = fevld_q;
  assign bus.state         = state_q;
`ifdef GATE_SWEEP_MAP_EN
  assign bus.result_map    = map_q;
`endif

endmodule
